// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port memory between instruction fetch and the load/store unit.
// Latency: 3 clks from request to ack with same-cycle grant and next-cycle rvalid; one IDLE bubble between accesses.
// Backpressure: mem_req held until mem_gnt; each requester holds its request until its ack; one access outstanding.
//
// Build option: define ARB_FAIR_EN to force a fetch after MAX_DGNT consecutive data grants;
// when undefined, data always wins and the grant counter does not exist.
//
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   f_req/f_addr/f_kill           fetch read request, address, taken-jump kill
//   f_ack/f_rdata                 one-cycle fetch completion pulse and instruction word
//   d_req/d_we/d_addr/d_wdata/d_be  load/store request and its fields
//   d_ack/d_rdata                 one-cycle data completion pulse and load data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  registered request to the memory macro
//   mem_gnt/mem_rvalid/mem_rdata  memory accept strobe, response strobe, read data
//
// Requests are sampled in IDLE, and IDLE is the cycle in which the previous ack is
// visible. A requester therefore drops or replaces its request in its ack cycle;
// a request still held then is taken as a new access.

module imem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_DGNT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              f_req,
    input  logic [AW-1:0]     f_addr,
    input  logic              f_kill,
    output logic              f_ack,
    output logic [DW-1:0]     f_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    input  logic [DW/8-1:0]   d_be,
    output logic              d_ack,
    output logic [DW-1:0]     d_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DW-1:0]     mem_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_F  = 3'd1,
        REQ_D  = 3'd2,
        WAIT_F = 3'd3,
        WAIT_D = 3'd4
    } state_t;

    state_t state;

    // Set when a fetch is killed after the memory has accepted it: the response
    // must still be consumed to keep the memory handshake balanced, but the
    // instruction is stale and must not be acked.
    logic   kill_flag;

    // Arbitration decision for the IDLE state.
    logic   f_elig;
    logic   take_d;
    logic   take_f;

    assign f_elig = f_req & ~f_kill;

`ifdef ARB_FAIR_EN
    localparam logic [2:0] MAX_CNT = 3'(MAX_DGNT);

    // Consecutive data grants since the last fetch grant, saturating at MAX_CNT.
    logic [2:0] dgnt_cnt;
    logic       fetch_starved;

    assign fetch_starved = (dgnt_cnt == MAX_CNT);
    assign take_d        = d_req & ~(fetch_starved & f_elig);
`else
    assign take_d        = d_req;
`endif

    assign take_f = f_elig & ~take_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            kill_flag <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            f_ack     <= 1'b0;
            f_rdata   <= '0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
`ifdef ARB_FAIR_EN
            dgnt_cnt  <= '0;
`endif
        end else begin
            // Acks are single-cycle pulses unless re-asserted below.
            f_ack <= 1'b0;
            d_ack <= 1'b0;

            case (state)
                IDLE: begin
                    kill_flag <= 1'b0;
                    // Latch the winner's fields now; the memory sees only these
                    // registered copies until the access completes.
                    if (take_d) begin
                        state     <= REQ_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                    end else if (take_f) begin
                        state     <= REQ_F;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= f_addr;
                        mem_wdata <= '0;
                        mem_be    <= '1;
                    end
                end

                REQ_F: begin
                    if (mem_gnt) begin
                        // Accepted: the response will come even if the fetch is
                        // killed in this same cycle, so remember the kill.
                        state   <= WAIT_F;
                        mem_req <= 1'b0;
                        if (f_kill) begin
                            kill_flag <= 1'b1;
                        end
`ifdef ARB_FAIR_EN
                        dgnt_cnt <= '0;
`endif
                    end else if (f_kill) begin
                        // Not yet accepted: withdraw the request outright.
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        kill_flag <= 1'b0;
                    end
                end

                REQ_D: begin
                    if (mem_gnt) begin
                        state   <= WAIT_D;
                        mem_req <= 1'b0;
`ifdef ARB_FAIR_EN
                        if (dgnt_cnt != MAX_CNT) begin
                            dgnt_cnt <= dgnt_cnt + 3'd1;
                        end
`endif
                    end
                end

                WAIT_F: begin
                    if (mem_rvalid) begin
                        state     <= IDLE;
                        kill_flag <= 1'b0;
                        // A kill arriving with the response still suppresses it.
                        if (!(kill_flag || f_kill)) begin
                            f_ack   <= 1'b1;
                            f_rdata <= mem_rdata;
                        end
                    end else if (f_kill) begin
                        kill_flag <= 1'b1;
                    end
                end

                WAIT_D: begin
                    if (mem_rvalid) begin
                        state   <= IDLE;
                        d_ack   <= 1'b1;
                        d_rdata <= mem_rdata;
                    end
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed bench for imem_arbiter with a responding memory model.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: model grant delay and response delay are programmable per step.

module tb_imem_arbiter;

    logic        clk;
    logic        rst;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_kill;
    logic        f_ack;
    logic [31:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    imem_arbiter #(.AW(32), .DW(32), .MAX_DGNT(4)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_kill(f_kill), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } dop_t;
    typedef struct packed { logic chk; logic [31:0] data; } dexp_t;
    typedef struct { logic we; logic [31:0] addr; int cyc; } acc_t;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;

    logic [31:0] f_ops[$];
    logic [31:0] fq[$];
    dop_t        d_ops[$];
    dexp_t       dq[$];
    acc_t        log_q[$];

    logic [31:0] mem_img [logic [31:0]];
    int gnt_delay = 0;
    int rv_delay  = 1;
    int wait_cnt  = 0;
    int rv_cnt    = 0;
    logic [31:0] rsp_data = '0;
    int n_rvalid = 0;
    int last_rv_cyc = 0;
    int n_fack = 0;
    int n_dack = 0;
    int last_fack_cyc = 0;
    int last_dack_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic present_f();
        if (f_ops.size() > 0) begin
            f_req  = 1'b1;
            f_addr = f_ops[0];
        end else begin
            f_req  = 1'b0;
        end
    endtask

    task automatic present_d();
        if (d_ops.size() > 0) begin
            d_req   = 1'b1;
            d_we    = d_ops[0].we;
            d_addr  = d_ops[0].addr;
            d_wdata = d_ops[0].wdata;
            d_be    = d_ops[0].be;
        end else begin
            d_req   = 1'b0;
        end
    endtask

    task automatic push_f(input logic [31:0] a, input logic [31:0] exp);
        f_ops.push_back(a);
        fq.push_back(exp);
        present_f();
    endtask

    task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp);
        dop_t  op;
        dexp_t e;
        op.we = we; op.addr = a; op.wdata = wd; op.be = be;
        e.chk = ~we; e.data = exp;
        d_ops.push_back(op);
        dq.push_back(e);
        present_d();
    endtask

    // One clock: ack scoreboard, requester drivers, then the memory model.
    task automatic tick();
        logic [31:0] m;
        @(posedge clk);
        #1;
        cyc++;
        if (f_ack === 1'b1 && d_ack === 1'b1) chk("dual_ack", {f_ack, d_ack}, 2'b01);
        if (f_ack === 1'b1) begin
            n_fack++;
            last_fack_cyc = cyc;
            chk("fack_expected", 32'(fq.size() > 0), 1);
            if (fq.size() > 0) chk("f_rdata", f_rdata, fq.pop_front());
            if (f_ops.size() > 0) f_ops.delete(0);
            present_f();
        end
        if (d_ack === 1'b1) begin
            n_dack++;
            last_dack_cyc = cyc;
            chk("dack_expected", 32'(dq.size() > 0), 1);
            if (dq.size() > 0) begin
                dexp_t e;
                e = dq.pop_front();
                if (e.chk) chk("d_rdata", d_rdata, e.data);
            end
            if (d_ops.size() > 0) d_ops.delete(0);
            present_d();
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hBAD0_BAD0;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                mem_rvalid  = 1'b1;
                mem_rdata   = rsp_data;
                n_rvalid++;
                last_rv_cyc = cyc;
            end
        end
        mem_gnt = 1'b0;
        if (mem_req === 1'b1) begin
            if (wait_cnt >= gnt_delay) begin
                acc_t a;
                mem_gnt  = 1'b1;
                wait_cnt = 0;
                a.we = mem_we; a.addr = mem_addr; a.cyc = cyc;
                log_q.push_back(a);
                if (mem_we) begin
                    m = {{8{mem_be[3]}}, {8{mem_be[2]}}, {8{mem_be[1]}}, {8{mem_be[0]}}};
                    mem_img[mem_addr] = (rd_word(mem_addr) & ~m) | (mem_wdata & m);
                    rsp_data = '0;
                end else begin
                    rsp_data = rd_word(mem_addr);
                end
                rv_cnt = rv_delay;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while ((f_ops.size() + d_ops.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_drain"}, 32'(f_ops.size() + d_ops.size()), 0);
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int sv;
        logic [31:0] exp6 [7];

        rst = 1'b1; f_req = 0; f_addr = 0; f_kill = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        mem_img[32'h100]  = 32'h0000_0013;
        mem_img[32'h104]  = 32'h00A0_0093;
        mem_img[32'h108]  = 32'h1111_1111;
        mem_img[32'h200]  = 32'h2222_2222;
        mem_img[32'h2000] = 32'hCAFE_F00D;
        mem_img[32'h3000] = 32'h1122_3344;

        // Reset state
        repeat (2) tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_acks", {f_ack, d_ack}, 0);
        chk("rst_rdata", f_rdata | d_rdata, 0);
        rst = 1'b0;
        tick();

        // 1: single fetch, immediate grant, 3-cycle latency
        c0 = cyc;
        push_f(32'h100, 32'h13);
        tick();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_we", mem_we, 0);
        tick();
        chk("t1_req_drop", mem_req, 0);
        tick();
        chk("t1_f_ack", f_ack, 1);
        chk("t1_d_ack", d_ack, 0);
        chk("t1_f_rdata", f_rdata, 32'h13);
        chk("t1_latency", 32'(last_fack_cyc - c0), 3);
        tick();
        chk("t1_ack_pulse", f_ack, 0);
        wait_drain(20, "t1");

        // 2: simultaneous requests, data wins, fetch after one IDLE bubble
        log_q.delete();
        push_d(1'b0, 32'h2000, 0, 4'hF, 32'hCAFE_F00D);
        push_f(32'h104, 32'h00A0_0093);
        wait_drain(40, "t2");
        chk("t2_n_access", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t2_first_addr", log_q[0].addr, 32'h2000);
            chk("t2_second_addr", log_q[1].addr, 32'h104);
            chk("t2_gnt_spacing", 32'(log_q[1].cyc - log_q[0].cyc), 3);
        end

        // 3: kill during WAIT_F, response consumed silently, next fetch normal
        rv_delay = 3;
        push_f(32'h108, 32'h1111_1111);
        tick();
        tick();
        f_kill = 1'b1;
        f_ops.delete(0);
        fq.delete(0);
        present_f();
        tick();
        f_kill = 1'b0;
        rv_delay = 1;
        sv = n_fack;
        push_f(32'h200, 32'h2222_2222);
        wait_drain(40, "t3");
        chk("t3_one_fack", 32'(n_fack - sv), 1);

        // Kill before grant: request withdrawn, nothing issued
        gnt_delay = 3;
        log_q.delete();
        sv = n_fack;
        push_f(32'h300, 32'h0);
        tick();
        chk("kreq_mem_req_on", mem_req, 1);
        f_kill = 1'b1;
        f_ops.delete(0);
        fq.delete(0);
        present_f();
        tick();
        f_kill = 1'b0;
        chk("kreq_mem_req_off", mem_req, 0);
        repeat (4) tick();
        chk("kreq_no_access", log_q.size(), 0);
        chk("kreq_no_fack", 32'(n_fack - sv), 0);
        gnt_delay = 0;

        // Kill in the same cycle as rvalid
        sv = n_fack;
        push_f(32'h104, 32'h0);
        tick();
        tick();
        f_kill = 1'b1;
        f_ops.delete(0);
        fq.delete(0);
        present_f();
        tick();
        f_kill = 1'b0;
        chk("krv_no_fack", f_ack, 0);
        repeat (2) tick();
        chk("krv_fack_cnt", 32'(n_fack - sv), 0);

        // f_kill during a data access has no effect
        push_d(1'b0, 32'h2000, 0, 4'hF, 32'hCAFE_F00D);
        tick();
        tick();
        f_kill = 1'b1;
        tick();
        f_kill = 1'b0;
        chk("kdata_d_ack", d_ack, 1);
        wait_drain(20, "kdata");

        // 4: write stalled 5 cycles by the memory; fields stay put
        gnt_delay = 5;
        push_d(1'b1, 32'h3000, 32'hDEAD_BEEF, 4'b0011, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_mem_req", mem_req, 1);
            chk("t4_fields", {31'(0), mem_we} ^ mem_addr ^ mem_wdata ^ {28'(0), mem_be},
                32'h1 ^ 32'h3000 ^ 32'hDEAD_BEEF ^ 32'h3);
            chk("t4_wdata", mem_wdata, 32'hDEAD_BEEF);
            if (i == 1) begin
                d_addr  = 32'h7777_0000;
                d_wdata = 32'h0BAD_0BAD;
                d_be    = 4'hF;
            end
        end
        wait_drain(30, "t4");
        chk("t4_ack_after_rv", 32'(last_dack_cyc - last_rv_cyc), 1);
        gnt_delay = 0;
        push_d(1'b0, 32'h3000, 0, 4'hF, 32'h1122_BEEF);
        wait_drain(20, "t4rb");

        // 5: reset while waiting for a data response; late rvalid ignored
        rv_delay = 4;
        push_d(1'b0, 32'h2000, 0, 4'hF, 32'hCAFE_F00D);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("t5_mem_req", mem_req, 0);
        chk("t5_acks", {f_ack, d_ack}, 0);
        chk("t5_mem_fields", mem_addr | {31'(0), mem_we} | {28'(0), mem_be}, 0);
        chk("t5_d_rdata", d_rdata, 0);
        rst = 1'b0;
        d_ops.delete();
        dq.delete();
        present_d();
        sv = n_dack;
        c0 = n_rvalid;
        repeat (5) tick();
        chk("t5_late_rvalid_seen", 32'(n_rvalid - c0), 1);
        chk("t5_no_dack", 32'(n_dack - sv), 0);
        chk("t5_idle_req", mem_req, 0);
        rv_delay = 1;

        // 6: six held data reads plus one fetch
        rst = 1'b1;
        tick();
        rst = 1'b0;
        log_q.delete();
        for (int i = 0; i < 6; i++) begin
            push_d(1'b0, 32'h5000 + 32'(i * 4), 0, 4'hF, (32'h5000 + 32'(i * 4)) ^ 32'h5A5A_0000);
        end
        push_f(32'h600, 32'h600 ^ 32'h5A5A_0000);
`ifdef ARB_FAIR_EN
        exp6 = '{32'h5000, 32'h5004, 32'h5008, 32'h500C, 32'h600, 32'h5010, 32'h5014};
`else
        exp6 = '{32'h5000, 32'h5004, 32'h5008, 32'h500C, 32'h5010, 32'h5014, 32'h600};
`endif
        wait_drain(80, "t6");
        chk("t6_n_access", log_q.size(), 7);
        if (log_q.size() == 7) begin
            for (int i = 0; i < 7; i++) chk("t6_order", log_q[i].addr, exp6[i]);
        end

        chk("end_fq_empty", 32'(fq.size() + dq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
